// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types, button indices, decimal-point codes and saturating BCD helpers
// for the two-team scoreboard controller.
// -----------------------------------------------------------------------------
package score_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } score_t;

    localparam int BTN_A_INC = 0;
    localparam int BTN_A_DEC = 1;
    localparam int BTN_B_INC = 2;
    localparam int BTN_B_DEC = 3;

    localparam logic [3:0] PT_A_LEAD = 4'b1000;
    localparam logic [3:0] PT_B_LEAD = 4'b0001;
    localparam logic [3:0] PT_TIE    = 4'b0000;

    // +1 with carry from ones to tens; 99 stays 99.
    function automatic score_t bcd_inc(input score_t s);
        score_t r;
        r = s;
        if (s.ones == 4'd9) begin
            if (s.tens != 4'd9) begin
                r.tens = s.tens + 4'd1;
                r.ones = 4'd0;
            end
        end else begin
            r.ones = s.ones + 4'd1;
        end
        return r;
    endfunction

    // -1 with borrow from tens to ones; 00 stays 00.
    function automatic score_t bcd_dec(input score_t s);
        score_t r;
        r = s;
        if (s.ones == 4'd0) begin
            if (s.tens != 4'd0) begin
                r.tens = s.tens - 4'd1;
                r.ones = 4'd9;
            end
        end else begin
            r.ones = s.ones - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_ctrl_if.sv
// -----------------------------------------------------------------------------
// score_ctrl_if
// Board-side bundle of the scoreboard controller.
//   btn[3:0]    raw buttons: [0]=A+1 [1]=A-1 [2]=B+1 [3]=B-1
//   clr         level-sensitive clear of both scores
//   hexs[15:0]  {A_tens, A_ones, B_tens, B_ones} BCD digits
//   les[3:0]    per-digit blink enables, same order as hexs nibbles
//   points[3:0] decimal points, [3]=A leads, [0]=B leads
// master: the board / stimulus side. slave: score_ctrl.
// -----------------------------------------------------------------------------
interface score_ctrl_if;
    logic [3:0]  btn;
    logic        clr;
    logic [15:0] hexs;
    logic [3:0]  les;
    logic [3:0]  points;

    modport master (
        output btn, clr,
        input  hexs, les, points
    );

    modport slave (
        input  btn, clr,
        output hexs, les, points
    );
endinterface

// File: rtl/score_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One button: 2-flop synchronizer, stability counter and rising-edge detector.
//   clk    system clock
//   RST    synchronous active-high reset
//   raw    asynchronous button input
//   level  debounced level
//   press  one-cycle pulse on each accepted rising edge of level
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (RST) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            // synchronizer stage boundary
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            // any agreement with the accepted level restarts the stability count
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= ~level;
                press <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_ctrl.sv
// -----------------------------------------------------------------------------
// score_ctrl
// Two-team scoreboard: debounces four buttons, keeps two saturating BCD scores
// (0..99) and drives the 4-digit display bus.
//   clk  system clock
//   RST  synchronous active-high reset
//   bus  score_ctrl_if.slave: btn, clr in; hexs, les, points out
// Optional build macro SCORE_BLINK_EN: per-team blink window of BLINK_CYCLES
// after each press-caused score change; otherwise les is constant 0.
// -----------------------------------------------------------------------------
module score_ctrl
    import score_pkg::*;
#(
    parameter int DEB_CYCLES   = 1000000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic         clk,
    input  logic         RST,
    score_ctrl_if.slave  bus
);

    logic [3:0] press;
    score_t     score_a, score_b;
    score_t     next_a, next_b;
    logic [3:0] points_q, points_next;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .RST   (RST),
            .raw   (bus.btn[i]),
            .level (),
            .press (press[i])
        );
    end

    // Opposing pulses in the same cycle cancel; clr wins over everything.
    always_comb begin
        next_a = score_a;
        next_b = score_b;
        if (press[BTN_A_INC] && !press[BTN_A_DEC]) begin
            next_a = bcd_inc(score_a);
        end else if (press[BTN_A_DEC] && !press[BTN_A_INC]) begin
            next_a = bcd_dec(score_a);
        end
        if (press[BTN_B_INC] && !press[BTN_B_DEC]) begin
            next_b = bcd_inc(score_b);
        end else if (press[BTN_B_DEC] && !press[BTN_B_INC]) begin
            next_b = bcd_dec(score_b);
        end
        if (bus.clr) begin
            next_a = '0;
            next_b = '0;
        end
        // BCD digits compare correctly as plain unsigned bytes
        if ({next_a} > {next_b}) begin
            points_next = PT_A_LEAD;
        end else if ({next_b} > {next_a}) begin
            points_next = PT_B_LEAD;
        end else begin
            points_next = PT_TIE;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            score_a  <= '0;
            score_b  <= '0;
            points_q <= PT_TIE;
        end else begin
            score_a  <= next_a;
            score_b  <= next_b;
            points_q <= points_next;
        end
    end

    assign bus.hexs   = {score_a, score_b};
    assign bus.points = points_q;

`ifdef SCORE_BLINK_EN
    localparam int TW = $clog2(BLINK_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(BLINK_CYCLES - 1);

    logic          changed_a, changed_b;
    logic [TW-1:0] tmr_a, tmr_b;
    logic          les_a, les_b;

    // clr forces next to 00, so it never counts as a change
    always_comb begin
        changed_a = !bus.clr && (next_a != score_a);
        changed_b = !bus.clr && (next_b != score_b);
    end

    // les is held for the change cycle plus the timer run-down, giving a
    // window of exactly BLINK_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (RST || bus.clr) begin
            tmr_a <= '0;
            tmr_b <= '0;
            les_a <= 1'b0;
            les_b <= 1'b0;
        end else begin
            les_a <= changed_a || (tmr_a != '0);
            les_b <= changed_b || (tmr_b != '0);
            if (changed_a) begin
                tmr_a <= TMR_LOAD;
            end else if (tmr_a != '0) begin
                tmr_a <= tmr_a - 1'b1;
            end
            if (changed_b) begin
                tmr_b <= TMR_LOAD;
            end else if (tmr_b != '0) begin
                tmr_b <= tmr_b - 1'b1;
            end
        end
    end

    assign bus.les = {les_a, les_a, les_b, les_b};
`else
    assign bus.les = 4'h0;
`endif

endmodule
